seg_scan_driver: RTL
====================

// Module: seg_scan_driver
// PURPOSE
//   Time-multiplexed scan driver for the 8-digit seven-segment display; the stage directly downstream of the
//   segment-pattern decoders. Takes eight 8-bit segment patterns and cycles digit selects with a dwell/guard
//   (anti-ghosting) sequence. Drives the board pins tubSel/tubLeft/tubRight. Inputs are latched once per frame (no tearing).
// PARAMETERS
//   DWELL_CYCLES  100000  clocks each digit is lit per visit (1 ms at 100 MHz); legal >= 2
//   GUARD_CYCLES  1000    clocks of all-off blanking between digits; legal >= 1
// PORTS
//   clk         in   1   system clock
//   rst         in   1   reset, asynchronous, active-low
//   seg_in      in   64  patterns; digit k (k=0 leftmost) = seg_in[63-8k -: 8], bit 1 = segment lit
//   digit_en    in   8   digit_en[7-k]=1 enables digit k; 0 keeps that digit dark
//   bright      in   3   duty level, used only with SEG_BRIGHTNESS_EN (ignored otherwise)
//   tub_sel     out  8   active-high digit select; digit k -> tub_sel[7-k]; at most one bit set
//   tub_left    out  8   segment bus for digits 0..3
//   tub_right   out  8   segment bus for digits 4..7
//   frame_done  out  1   one-cycle pulse at end of digit 7 dwell
// BEHAVIOUR
//   - All outputs registered. Reset: tub_sel=0, tub_left=0, tub_right=0, frame_done=0, shadow=0, idx=0, cnt=0, state=GUARD.
//   - States: GUARD -> DWELL -> GUARD ...; cnt counts 0..N-1 within state, cleared on every transition.
//   - GUARD: tub_sel=0, tub_left=0, tub_right=0. Lasts GUARD_CYCLES clocks. On its last cycle, if idx==0,
//     shadow <= seg_in (frame latch). Then -> DWELL.
//   - DWELL: lasts DWELL_CYCLES clocks. Outputs (registered) on every DWELL cycle:
//       tub_sel   = digit_en[7-idx] ? (8'b1 << (7-idx)) : 0
//       tub_left  = (idx<4 && digit_en[7-idx]) ? shadow[63-8*idx -: 8] : 0
//       tub_right = (idx>=4 && digit_en[7-idx]) ? shadow[63-8*idx -: 8] : 0
//     Last cycle: idx <= idx+1 (3-bit wrap 7->0), -> GUARD; if idx==7, frame_done=1 for that one cycle.
//   - Output registers lag state by one clock: first lit cycle is the clock after GUARD's last cycle.
//   - Frame period = 8*(DWELL_CYCLES+GUARD_CYCLES) clocks. seg_in changes appear at next frame latch;
//     worst-case latency one frame + GUARD_CYCLES + 1. seg_in change between latches has no visible effect.
//   - digit_en sampled live every cycle (not frame-latched); deasserting mid-dwell darkens next cycle.
//   - Never two tub_sel bits high; tub_left/tub_right never both non-zero.
//   - Reset mid-frame: immediate async return to reset values; scan restarts at digit 0 after full GUARD.
//   - Counter width = clog2(max(DWELL_CYCLES,GUARD_CYCLES)); no other wrap besides idx.
// CONFIGURATION
//   SEG_BRIGHTNESS_EN defined: 3-bit pwm counter free-runs during DWELL (reset to 0 on DWELL entry);
//     digit lit (as above) only on cycles with pwm <= bright, else tub_sel/tub_left/tub_right = 0.
//     bright=7 -> full on, bright=0 -> 1/8 duty. bright sampled live.
//   Not defined: no pwm logic; bright unused; digit lit for entire DWELL.
// TESTING (DWELL_CYCLES=4, GUARD_CYCLES=2)
//   - Reset release, seg_in=64'h0102040810204080, digit_en=8'hFF -> tub_sel=0 for 3 clks, then 8'h80 with
//     tub_left=8'h01 for 4 clks, 2 clks all-zero, then 8'h40/tub_left=8'h02; digit 4: tub_sel=8'h08, tub_right=8'h10.
//   - Check frame_done pulses once per 48 clks, coincident with last DWELL cycle of digit 7 (tub_sel=8'h01).
//   - Change seg_in mid-frame to 64'hFF.. -> displayed patterns unchanged until the next digit-0 dwell, then all 8'hFF.
//   - digit_en=8'b1011_1111 -> digit 1 slot: tub_sel=0, tub_left=0 for its 4 dwell clks; timing of other digits unchanged.
//   - Assert rst during digit 5 dwell -> all outputs 0 same cycle; after release, scan restarts at digit 0 after 2-clk guard.
//   - SEG_BRIGHTNESS_EN, DWELL_CYCLES=16, bright=1 -> each digit lit 4 of 16 dwell clks (pwm 0,1 of each 8); bright=7 -> 16 of 16.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Eight-digit seven-segment scan driver: per-frame pattern latch, dwell/guard digit sequencing, registered pins.
// Optional SEG_BRIGHTNESS_EN adds a 3-bit PWM duty gate driven by 'bright'.
module seg_scan_driver #(
  parameter int DWELL_CYCLES = 100000,
  parameter int GUARD_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] seg_in,
  input  logic [7:0]  digit_en,
  input  logic [2:0]  bright,
  output logic [7:0]  tub_sel,
  output logic [7:0]  tub_left,
  output logic [7:0]  tub_right,
  output logic        frame_done
);

  localparam int MAX_CYCLES = (DWELL_CYCLES > GUARD_CYCLES) ? DWELL_CYCLES : GUARD_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);

  typedef enum logic {GUARD, DWELL} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [63:0]   shadow_q, shadow_d;
  logic [7:0]    tub_sel_q, tub_sel_d;
  logic [7:0]    tub_left_q, tub_left_d;
  logic [7:0]    tub_right_q, tub_right_d;
  logic          frame_done_q, frame_done_d;
  logic [2:0]    pos;
  logic [7:0]    pat;
  logic          lit;

`ifdef SEG_BRIGHTNESS_EN
  logic [2:0]    pwm_q, pwm_d;
`else
  logic          unused_bright;
  assign unused_bright = ^bright;
`endif

  // Digit k sits at bit position 7-k in both digit_en/tub_sel and the byte order of the shadow.
  assign pos = 3'd7 - idx_q;
  assign pat = shadow_q[{pos, 3'b000} +: 8];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    tub_sel_d    = 8'h00;
    tub_left_d   = 8'h00;
    tub_right_d  = 8'h00;
    frame_done_d = 1'b0;
    lit          = digit_en[pos];
`ifdef SEG_BRIGHTNESS_EN
    pwm_d        = pwm_q;
    lit          = lit && (pwm_q <= bright);
`endif
    case (state_q)
      GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          cnt_d   = '0;
          state_d = DWELL;
          if (idx_q == 3'd0) shadow_d = seg_in;
`ifdef SEG_BRIGHTNESS_EN
          pwm_d   = 3'd0;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DWELL: begin
        if (lit) begin
          tub_sel_d = 8'b1 << pos;
          if (idx_q[2]) tub_right_d = pat;
          else          tub_left_d  = pat;
        end
`ifdef SEG_BRIGHTNESS_EN
        pwm_d = pwm_q + 3'd1;
`endif
        if (cnt_q == DWELL_LAST) begin
          cnt_d        = '0;
          idx_d        = idx_q + 3'd1;
          state_d      = GUARD;
          frame_done_d = (idx_q == 3'd7);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = GUARD;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= GUARD;
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      shadow_q     <= 64'h0;
      tub_sel_q    <= 8'h00;
      tub_left_q   <= 8'h00;
      tub_right_q  <= 8'h00;
      frame_done_q <= 1'b0;
`ifdef SEG_BRIGHTNESS_EN
      pwm_q        <= 3'd0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      tub_sel_q    <= tub_sel_d;
      tub_left_q   <= tub_left_d;
      tub_right_q  <= tub_right_d;
      frame_done_q <= frame_done_d;
`ifdef SEG_BRIGHTNESS_EN
      pwm_q        <= pwm_d;
`endif
    end
  end

  assign tub_sel    = tub_sel_q;
  assign tub_left   = tub_left_q;
  assign tub_right  = tub_right_q;
  assign frame_done = frame_done_q;

endmodule
